ps2_receiver: RTL



---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_filter.sv | 52 +++++
 rtl/ps2_receiver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: scan-code constants,
// frame FSM encoding, default timing parameters and frame-check helpers.
package ps2_pkg;

    localparam int FILTER_DEFAULT  = 8;
    localparam int TIMEOUT_DEFAULT = 56000;

    localparam logic [7:0] KC_E0 = 8'hE0;
    localparam logic [7:0] KC_E1 = 8'hE1;
    localparam logic [7:0] KC_F0 = 8'hF0;
    localparam logic [7:0] KC_AA = 8'hAA;
    localparam logic [7:0] KC_FA = 8'hFA;
    localparam logic [7:0] KC_FE = 8'hFE;
    localparam logic [7:0] KC_EE = 8'hEE;
    localparam logic [7:0] KC_00 = 8'h00;
    localparam logic [7:0] KC_FF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Per-pin conditioning: 2-FF synchroniser, saturating glitch filter and a
// registered falling-edge pulse of the filtered level.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER = FILTER_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, then flip the level after FILTER consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            fall_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            fall_r  <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CW'(FILTER - 1)) begin
                    level_r <= sync2_r;
                    cnt_r   <= '0;
                    fall_r  <= ~sync2_r;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: frames 11-bit packets, checks parity/framing,
// recovers from stalls and decodes E0/F0/E1 prefixes into make/break events.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER  = FILTER_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       strobe,
    output logic       pressed,
    output logic [7:0] code,
    output logic       extended,
    output logic       error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic ck_level_s;
    logic fe_s;
    logic d_s;
    logic d_fall_s;
    logic unused_s;

    ps2_filter #(.FILTER(FILTER)) u_ck_filter (
        .clock (clock),
        .reset (reset),
        .pin   (ps2Ck),
        .level (ck_level_s),
        .fall  (fe_s)
    );

    ps2_filter #(.FILTER(FILTER)) u_d_filter (
        .clock (clock),
        .reset (reset),
        .pin   (ps2D),
        .level (d_s),
        .fall  (d_fall_s)
    );

    assign unused_s = ck_level_s ^ d_fall_s;

    ps2_state_e    state_r;
    ps2_state_e    state_n_s;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [TW-1:0] to_cnt_r;
    logic          timeout_s;
    logic          frame_ok_s;
    logic          frame_err_s;
    logic          frame_err_r;
    logic          byte_valid_r;
    logic [7:0]    byte_r;

    logic          strobe_r;
    logic          pressed_r;
    logic [7:0]    code_r;
    logic          extended_r;
    logic          error_r;
    logic          release_flag_r;
    logic          ext_flag_r;
    logic [2:0]    skip_r;

    // An fe in the same cycle always beats an expiring timeout.
    assign timeout_s = (state_r != ST_IDLE) && !fe_s && (to_cnt_r == TW'(TIMEOUT - 1));

    // Frame FSM next-state and frame verdicts.
    always_comb begin
        state_n_s   = state_r;
        frame_ok_s  = 1'b0;
        frame_err_s = 1'b0;
        if (fe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!d_s) begin
                        state_n_s = ST_DATA;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 3'd7) begin
                        state_n_s = ST_PARITY;
                    end else begin
                        state_n_s = ST_DATA;
                    end
                end
                ST_PARITY: state_n_s = ST_STOP;
                ST_STOP: begin
                    if (d_s && odd_parity_ok(shift_r, par_r)) begin
                        frame_ok_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                    state_n_s = ST_IDLE;
                end
                default: state_n_s = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            state_n_s   = ST_IDLE;
            frame_err_s = 1'b1;
        end else begin
            state_n_s = state_r;
        end
    end

    // Frame state, bit shifting and stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            par_r        <= 1'b0;
            to_cnt_r     <= '0;
            frame_err_r  <= 1'b0;
            byte_valid_r <= 1'b0;
            byte_r       <= 8'h00;
        end else begin
            state_r      <= state_n_s;
            frame_err_r  <= frame_err_s;
            byte_valid_r <= frame_ok_s;
            if (fe_s || state_r == ST_IDLE) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
            if (fe_s) begin
                case (state_r)
                    ST_IDLE:   bit_cnt_r <= 3'd0;
                    ST_DATA: begin
                        shift_r   <= {d_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end
                    ST_PARITY: par_r  <= d_s;
                    ST_STOP:   byte_r <= shift_r;
                    default:   bit_cnt_r <= 3'd0;
                endcase
            end
        end
    end

    // Prefix decoder and registered event outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            strobe_r       <= 1'b0;
            pressed_r      <= 1'b0;
            code_r         <= 8'h00;
            extended_r     <= 1'b0;
            error_r        <= 1'b0;
            release_flag_r <= 1'b0;
            ext_flag_r     <= 1'b0;
            skip_r         <= 3'd0;
        end else begin
            strobe_r <= 1'b0;
            error_r  <= frame_err_r;
            if (byte_valid_r) begin
                if (skip_r != 3'd0) begin
                    skip_r <= skip_r - 3'd1;
                end else begin
                    case (byte_r)
                        KC_E1: skip_r         <= 3'd7;
                        KC_E0: ext_flag_r     <= 1'b1;
                        KC_F0: release_flag_r <= 1'b1;
                        KC_AA, KC_FA, KC_FE, KC_EE, KC_00, KC_FF: skip_r <= 3'd0;
                        default: begin
                            strobe_r       <= 1'b1;
                            code_r         <= byte_r;
                            pressed_r      <= ~release_flag_r;
                            extended_r     <= ext_flag_r;
                            release_flag_r <= 1'b0;
                            ext_flag_r     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign strobe   = strobe_r;
    assign pressed  = pressed_r;
    assign code     = code_r;
    assign extended = extended_r;
    assign error    = error_r;

endmodule
